// File: rtl/cpu_8bit.sv
// 8-bit accumulator CPU: 32x8 memory, 2-cycle FETCH/EXEC core, always-on 8N1 UART loader (no flow control).
// Optional macro CPU_ALU_EXT_EN enables ADD (010) and AND (011); otherwise both decode as NOPs.
module cpu_8bit #(
  parameter int Baudrate = 24
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Load,
  input  logic       RX,
  output logic       FE,
  output logic [7:0] Instruction,
  output logic [7:0] Acc,
  output logic [7:0] Mem,
  output logic [4:0] Program_counter
);

  localparam int CW = $clog2(Baudrate + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(Baudrate - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(Baudrate / 2 - 1);

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
`ifdef CPU_ALU_EXT_EN
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
`endif
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {HALT, FETCH, EXEC} core_state_e;

  rx_state_e   rx_state_q, rx_state_d;
  core_state_e state_q, state_d;

  logic          rx_s1_q, rx_s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          fe_q, fe_d;
  logic [4:0]    load_addr_q, load_addr_d;
  logic          load_q;
  logic [4:0]    pc_q, pc_d;
  logic [7:0]    acc_q, acc_d;
  logic [7:0]    ir_q, ir_d;
  logic [7:0]    mem_q [32];

  logic       uart_we, sto_we, mem_we;
  logic [4:0] uart_addr, mem_wa;
  logic [7:0] mem_wd, operand;
  logic       load_rise, load_fall;
  logic [2:0] opcode;

  assign load_rise = Load & ~load_q;
  assign load_fall = ~Load & load_q;
  assign opcode    = ir_q[7:5];
  assign operand   = mem_q[ir_q[4:0]];

  // UART receiver: all sampling is done on the synchronized line rx_s2_q
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    fe_d       = fe_q;
    uart_we    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d      = '0;
          bit_idx_d  = 3'd0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d      = '0;
          fe_d       = ~rx_s2_q;
          uart_we    = rx_s2_q & Load;
          rx_state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // A byte completing in the same cycle as the Load rising edge lands at address 0
  always_comb begin
    uart_addr   = load_rise ? 5'd0 : load_addr_q;
    load_addr_d = uart_we ? uart_addr + 5'd1 : uart_addr;
  end

  always_comb begin
    state_d = state_q;
    if (Load) begin
      state_d = HALT;
    end else if (load_fall) begin
      state_d = FETCH;
    end else begin
      case (state_q)
        HALT:    state_d = HALT;
        FETCH:   state_d = EXEC;
        EXEC:    state_d = (opcode == OP_HLT) ? HALT : FETCH;
        default: state_d = HALT;
      endcase
    end
  end

  always_comb begin
    pc_d   = pc_q;
    acc_d  = acc_q;
    ir_d   = ir_q;
    sto_we = 1'b0;
    if (Load) begin
      pc_d = pc_q;
    end else if (load_fall) begin
      pc_d  = 5'd0;
      acc_d = 8'd0;
      ir_d  = 8'd0;
    end else if (state_q == FETCH) begin
      ir_d = mem_q[pc_q];
      pc_d = pc_q + 5'd1;
    end else if (state_q == EXEC) begin
      case (opcode)
        OP_SKZ: if (acc_q == 8'd0) pc_d = pc_q + 5'd1;
`ifdef CPU_ALU_EXT_EN
        OP_ADD: acc_d = acc_q + operand;
        OP_AND: acc_d = acc_q & operand;
`endif
        OP_XOR: acc_d = acc_q ^ operand;
        OP_LDA: acc_d = operand;
        OP_STO: sto_we = 1'b1;
        OP_JMP: pc_d = ir_q[4:0];
        default: acc_d = acc_q;
      endcase
    end
  end

  // UART writes need Load=1 and STO needs Load=0, so the two never coincide
  always_comb begin
    mem_we = uart_we | sto_we;
    mem_wa = uart_we ? uart_addr : ir_q[4:0];
    mem_wd = uart_we ? shift_q : acc_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= HALT;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) rx_state_q <= RX_IDLE;
    else       rx_state_q <= rx_state_d;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      fe_q        <= 1'b0;
      load_addr_q <= 5'd0;
      load_q      <= 1'b0;
      pc_q        <= 5'd0;
      acc_q       <= 8'd0;
      ir_q        <= 8'd0;
    end else begin
      rx_s1_q     <= RX;
      rx_s2_q     <= rx_s1_q;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      fe_q        <= fe_d;
      load_addr_q <= load_addr_d;
      load_q      <= Load;
      pc_q        <= pc_d;
      acc_q       <= acc_d;
      ir_q        <= ir_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  assign FE              = fe_q;
  assign Instruction     = ir_q;
  assign Acc             = acc_q;
  assign Mem             = operand;
  assign Program_counter = pc_q;

endmodule

// File: tb/tb_cpu_8bit.sv
// Directed bench for cpu_8bit: UART loading, frame errors, table of program runs, async reset.
module tb_cpu_8bit;

  localparam int BAUD = 24;

  logic       Clk = 1'b0;
  logic       Reset, Load, RX, FE;
  logic [7:0] Instruction, Acc, Mem;
  logic [4:0] Program_counter;

  int total = 0;
  int bad   = 0;

  cpu_8bit #(.Baudrate(BAUD)) dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .RX(RX), .FE(FE),
    .Instruction(Instruction), .Acc(Acc), .Mem(Mem),
    .Program_counter(Program_counter)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [255:0] prog;
    logic [5:0]   len;
    logic [7:0]   exp_ir;
    logic [7:0]   exp_acc;
    logic [7:0]   exp_mem;
    logic [4:0]   exp_pc;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    RX = 1'b0;
    repeat (BAUD) @(negedge Clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BAUD) @(negedge Clk);
    end
    if (good) begin
      RX = 1'b1;
      repeat (BAUD) @(negedge Clk);
    end else begin
      RX = 1'b0;
      repeat (BAUD / 2 + 4) @(negedge Clk);
      RX = 1'b1;
      repeat (2 * BAUD) @(negedge Clk);
    end
  endtask

  task automatic run_program(input logic [255:0] p, input int n);
    @(negedge Clk);
    Load = 1'b0;
    @(negedge Clk);
    Load = 1'b1;
    repeat (2) @(negedge Clk);
    for (int i = 0; i < n; i++) send_byte(p[i*8 +: 8], 1'b1);
    repeat (2) @(negedge Clk);
    Load = 1'b0;
    repeat (60) @(negedge Clk);
  endtask

  initial begin
    vecs[0].prog    = 256'h00E30000000000E0_0000209B00F4209B_0020BCDCBADC00EA_20BB0020BA0000FE;
    vecs[0].len     = 6'd32;
    vecs[0].exp_ir  = 8'h00; vecs[0].exp_acc = 8'h00; vecs[0].exp_mem = 8'hFE; vecs[0].exp_pc = 5'h0A;
    // JMP 1F; SKZ at 1F wraps PC to 0 and skips to LDA 3
    vecs[1].prog    = 256'h2000000000000000_0000000000000000_0000000000000000_00000000770_0A3FF >> 4;
    vecs[1].prog    = {8'h20, 216'h0, 8'h77, 8'h00, 8'hA3, 8'hFF};
    vecs[1].len     = 6'd32;
    vecs[1].exp_ir  = 8'h00; vecs[1].exp_acc = 8'h77; vecs[1].exp_mem = 8'hFF; vecs[1].exp_pc = 5'h03;
    vecs[2].prog    = {200'h0, 56'h550FC6002085A5};
    vecs[2].len     = 6'd7;
    vecs[2].exp_ir  = 8'h0F; vecs[2].exp_acc = 8'h00; vecs[2].exp_mem = 8'h00; vecs[2].exp_pc = 5'h06;
    vecs[3].prog    = {208'h0, 48'hF03C006545A4};
    vecs[3].len     = 6'd6;
    vecs[3].exp_ir  = 8'h00; vecs[3].exp_mem = 8'hA4; vecs[3].exp_pc = 5'h04;
`ifdef CPU_ALU_EXT_EN
    vecs[3].exp_acc = 8'h20;
`else
    vecs[3].exp_acc = 8'h3C;
`endif

    Reset = 1'b1; Load = 1'b0; RX = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("reset_acc", 32'(Acc), 32'h00);
    check("reset_ir", 32'(Instruction), 32'h00);
    check("reset_pc", 32'(Program_counter), 32'h00);
    check("reset_fe", 32'(FE), 32'h0);

    Load = 1'b1;
    repeat (3) @(negedge Clk);
    send_byte(8'hFE, 1'b1);
    repeat (4) @(negedge Clk);
    check("byte0_mem", 32'(dut.mem_q[0]), 32'hFE);
    check("byte0_fe", 32'(FE), 32'h0);
    check("byte0_addr", 32'(dut.load_addr_q), 32'h1);

    send_byte(8'h33, 1'b0);
    check("bad_fe", 32'(FE), 32'h1);
    check("bad_addr", 32'(dut.load_addr_q), 32'h1);
    send_byte(8'h5A, 1'b1);
    repeat (4) @(negedge Clk);
    check("good_fe", 32'(FE), 32'h0);
    check("good_mem", 32'(dut.mem_q[1]), 32'h5A);
    check("good_addr", 32'(dut.load_addr_q), 32'h2);

    for (int v = 0; v < 4; v++) begin
      run_program(vecs[v].prog, int'(vecs[v].len));
      check($sformatf("v%0d_ir", v), 32'(Instruction), 32'(vecs[v].exp_ir));
      check($sformatf("v%0d_acc", v), 32'(Acc), 32'(vecs[v].exp_acc));
      check($sformatf("v%0d_mem", v), 32'(Mem), 32'(vecs[v].exp_mem));
      check($sformatf("v%0d_pc", v), 32'(Program_counter), 32'(vecs[v].exp_pc));
      check($sformatf("v%0d_fe", v), 32'(FE), 32'h0);
      if (v == 2) check("sto_mem6", 32'(dut.mem_q[6]), 32'h00);
    end

    // endless LDA 2 / JMP 0 loop, then reset while it runs
    run_program({232'h0, 24'h5AE0A2}, 3);
    check("loop_acc", 32'(Acc), 32'h5A);
    @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("arst_pc", 32'(Program_counter), 32'h00);
    check("arst_acc", 32'(Acc), 32'h00);
    check("arst_ir", 32'(Instruction), 32'h00);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (10) @(negedge Clk);
    check("halt_pc", 32'(Program_counter), 32'h00);
    check("halt_ir", 32'(Instruction), 32'h00);
    check("halt_acc", 32'(Acc), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
